i2c_regbank: RTL

I2C_REGBANK -- requirements
Module: i2c_regbank

---
 rtl/i2c_pkg.sv | 15 +
 rtl/i2c_regbank.sv | 130 +++++++++++++
 2 files changed

// File: rtl/i2c_pkg.sv
// Shared types and defaults for the I2C register bank.
package i2c_pkg;

    // Transaction state of the register bank
    typedef enum logic [2:0] {
        IDLE,
        WPTR,
        WDATA,
        RDATA,
        RDONE
    } state_t;

    localparam int unsigned NREGS_DEFAULT = 16;

endpackage

// File: rtl/i2c_regbank.sv
// I2C-facing register bank: a byte-wide register file written and read by an
// I2C slave front end, with a local host port for direct access.
// Optional feature: define I2C_REGBANK_AUTOINC_EN to advance the register
// pointer after every I2C data write and every read dequeue.
module i2c_regbank
    import i2c_pkg::*;
#(
    parameter  int unsigned NREGS = NREGS_DEFAULT,
    localparam int unsigned PTRW  = $clog2(NREGS)
) (
    input  logic            clk6x,
    input  logic            resetn,
    input  logic            devsel_i,
    input  logic            rw_bit_i,
    input  logic [7:0]      rxbyte_i,
    input  logic            rxbyte_v_i,
    output logic [7:0]      txbyte_o,
    input  logic            txbyte_deq_i,
    input  logic            tx_nacked_i,
    input  logic [PTRW-1:0] host_addr_i,
    input  logic [7:0]      host_wdata_i,
    input  logic            host_we_i,
    output logic [7:0]      host_rdata_o,
    output logic            wr_strobe_o,
    output logic [PTRW-1:0] wr_addr_o
);

`ifdef I2C_REGBANK_AUTOINC_EN
    localparam logic [PTRW-1:0] PTR_STEP = PTRW'(1);
`else
    localparam logic [PTRW-1:0] PTR_STEP = '0;
`endif

    state_t          state_q, state_d;
    logic [PTRW-1:0] ptr_q, ptr_d;
    logic [7:0]      regs_q [NREGS];
    logic            devsel_q;
    logic            rw_q;
    logic            armed_q;
    logic            wr_strobe_q, wr_strobe_d;
    logic [PTRW-1:0] wr_addr_q;
    logic            start;

    // A transaction starts on a devsel rise or on a Read/nWrite flip while
    // selected (repeated start). armed_q stays low after reset until devsel
    // has been seen low, so a transaction cut by reset is not resumed.
    assign start = devsel_i && armed_q && (!devsel_q || (rw_bit_i != rw_q));

    // Next-state, pointer update and I2C write request
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        wr_strobe_d = 1'b0;
        if (!devsel_i) begin
            state_d = IDLE;
        end else if (start) begin
            state_d = rw_bit_i ? RDATA : WPTR;
        end else begin
            case (state_q)
                WPTR: begin
                    if (rxbyte_v_i) begin
                        ptr_d   = rxbyte_i[PTRW-1:0];
                        state_d = WDATA;
                    end
                end
                WDATA: begin
                    if (rxbyte_v_i) begin
                        wr_strobe_d = 1'b1;
                        ptr_d       = ptr_q + PTR_STEP;
                    end
                end
                RDATA: begin
                    if (txbyte_deq_i) begin
                        ptr_d = ptr_q + PTR_STEP;
                    end
                    if (tx_nacked_i) begin
                        state_d = RDONE;
                    end
                end
                RDONE:   state_d = RDONE;
                IDLE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State, pointer, edge-detect history and write-report registers
    always_ff @(posedge clk6x) begin
        if (!resetn) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            devsel_q    <= 1'b0;
            rw_q        <= 1'b0;
            armed_q     <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            devsel_q    <= devsel_i;
            rw_q        <= rw_bit_i;
            armed_q     <= armed_q || !devsel_i;
            wr_strobe_q <= wr_strobe_d;
            if (wr_strobe_d) begin
                wr_addr_q <= ptr_q;
            end
        end
    end

    // Register file; the host write is issued last so it wins a same-address
    // collision with an I2C write in the same cycle.
    always_ff @(posedge clk6x) begin
        if (!resetn) begin
            regs_q <= '{default: '0};
        end else begin
            if (wr_strobe_d) begin
                regs_q[ptr_q] <= rxbyte_i;
            end
            if (host_we_i) begin
                regs_q[host_addr_i] <= host_wdata_i;
            end
        end
    end

    assign txbyte_o     = regs_q[ptr_q];
    assign host_rdata_o = regs_q[host_addr_i];
    assign wr_strobe_o  = wr_strobe_q;
    assign wr_addr_o    = wr_addr_q;

endmodule
